// File: rtl/scan_encoder_pkg.sv
// rtl/scan_encoder_pkg.sv - shared types and width helpers for the scan encoder
package scan_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DEFAULT_N = 8;

    function automatic int code_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_encoder_if.sv
// rtl/scan_encoder_if.sv - request-vector input and code-stream output bundle
interface scan_encoder_if #(
    parameter int N = scan_encoder_pkg::DEFAULT_N
) ();
    import scan_encoder_pkg::*;

    localparam int CW = code_width(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_code;
    logic [CW:0]   out_idx;
    logic          out_last;
    logic          out_zero;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_code, out_idx, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_code, out_idx, out_last, out_zero
    );

endinterface

// File: rtl/scan_encoder_prio_encoder.sv
// rtl/scan_encoder_prio_encoder.sv - combinational highest-set-bit finder
module prio_encoder
    import scan_encoder_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    localparam int CW = code_width(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [CW-1:0] o_code,
    output logic          o_any
);

    // Ascending scan so the highest set bit is the last assignment to win.
    always_comb begin
        o_code = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_code = CW'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/scan_encoder.sv
// rtl/scan_encoder.sv - streams the binary index of every set request bit, highest first
module scan_encoder
    import scan_encoder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic          clk,
    input  logic          rst,
    scan_encoder_if.slave bus
);

    localparam int           CW  = code_width(N);
    localparam logic [N-1:0] ONE = N'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_pending;
    logic [N-1:0]  w_pending_nxt;
    logic [CW:0]   r_idx;
    logic [CW:0]   w_idx_nxt;
    logic [CW-1:0] w_code;
    logic          w_any;
    logic          w_single;
    logic          w_scan;

    prio_encoder #(.N(N)) u_prio (
        .i_vec  (r_pending),
        .o_code (w_code),
        .o_any  (w_any)
    );

    // At most one bit left: clearing the lowest set bit leaves nothing.
    assign w_single = (r_pending & (r_pending - ONE)) == '0;
    assign w_scan   = (r_state == SCAN);

    assign bus.in_ready  = (r_state == IDLE) & ~rst;
    assign bus.out_valid = w_scan;
    assign bus.out_code  = w_code;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = w_scan & w_single;
    assign bus.out_zero  = w_scan & ~w_any;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_idx_nxt     = r_idx;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_pending_nxt = bus.in_vec;
                    w_idx_nxt     = '0;
                    w_state_nxt   = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    w_pending_nxt = r_pending & ~(ONE << w_code);
                    w_idx_nxt     = r_idx + 1'b1;
                    if (w_single) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

endmodule

// File: tb/tb_scan_encoder.sv
// tb/tb_scan_encoder.sv - randomized scoreboard bench for scan_encoder
module tb_scan_encoder;

    typedef struct {
        logic [2:0] code;
        logic [3:0] idx;
        logic       last;
        logic       zero;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_ready = 1'b0;
    beat_t sb[$];
    beat_t hold;
    bit    have_hold = 1'b0;

    scan_encoder_if #(.N(8)) bus ();

    scan_encoder #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: list set bits from the top down; an empty vector is one zero beat.
    task automatic push_expected(input logic [7:0] v);
        int cnt;
        int k;
        beat_t b;
        cnt = $countones(v);
        k = 0;
        if (cnt == 0) begin
            b.code = 3'd0; b.idx = 4'd0; b.last = 1'b1; b.zero = 1'b1;
            sb.push_back(b);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    b.code = 3'(i); b.idx = 4'(k); b.last = (k == cnt - 1); b.zero = 1'b0;
                    sb.push_back(b);
                    k++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [7:0] v);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (acc) push_expected(v);
        else check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && sb.size() != 0; t++) tick();
        check("drain_done", sb.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (rst) begin
            have_hold = 1'b0;
        end else if (bus.out_valid) begin
            cur.code = bus.out_code; cur.idx = bus.out_idx;
            cur.last = bus.out_last; cur.zero = bus.out_zero;
            if (have_hold) begin
                check("hold_code", cur.code, hold.code);
                check("hold_idx",  cur.idx,  hold.idx);
                check("hold_last", cur.last, hold.last);
                check("hold_zero", cur.zero, hold.zero);
            end
            if (bus.out_ready) begin
                have_hold = 1'b0;
                if (sb.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("beat_code", cur.code, e.code);
                    check("beat_idx",  cur.idx,  e.idx);
                    check("beat_last", cur.last, e.last);
                    check("beat_zero", cur.zero, e.zero);
                end
            end else begin
                hold = cur;
                have_hold = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] v;
        bus.in_valid  = 1'b0;
        bus.in_vec    = 8'h00;
        bus.out_ready = 1'b0;

        #3;
        check("rst_in_ready",  bus.in_ready,  32'd0);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_idx",   bus.out_idx,   32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 32'd1);
        tick();

        // Sparse vector with continuous ready: three back-to-back beats then idle.
        bus.out_ready = 1'b1;
        send(8'hA4);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check("sparse_valid", bus.out_valid, 32'd1);
            tick();
        end
        @(negedge clk);
        check("sparse_in_ready", bus.in_ready, 32'd1);
        check("sparse_done",     bus.out_valid, 32'd0);
        tick();

        send(8'h00);
        drain();

        // Backpressure with an in_valid pulse that must be ignored mid-scan.
        bus.out_ready = 1'b0;
        send(8'h81);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_valid", bus.out_valid, 32'd1);
            check("bp_code",  bus.out_code,  32'd7);
            if (c == 2) check("bp_in_ready", bus.in_ready, 32'd0);
            tick();
            if (c == 1) begin
                bus.in_valid = 1'b1;
                bus.in_vec   = 8'h3C;
            end
            if (c == 2) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            send(v);
        end
        for (int n = 0; n < 1000; n++) begin
            v = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            send(v);
        end
        drain();

        // Reset mid-scan: the aborted vector must leave no stale beats.
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        send(8'hFF);
        tick();
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_out_valid", bus.out_valid, 32'd0);
        check("mid_rst_in_ready",  bus.in_ready,  32'd0);
        check("mid_rst_out_code",  bus.out_code,  32'd0);
        check("mid_rst_out_idx",   bus.out_idx,   32'd0);
        check("mid_rst_out_last",  bus.out_last,  32'd0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release_ready", bus.in_ready, 32'd1);
        tick();
        send(8'h10);
        drain();
        tick();
        @(negedge clk);
        check("final_idle", bus.out_valid, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
